// File: rtl/anti_theft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : anti_theft_pkg
// Description : Shared encodings, state type and default durations for the
//               anti-theft timer and the FSM that drives it.
// Revision    : 1.0 - initial release
// ============================================================================
package anti_theft_pkg;

    // Interval / duration-register selector encoding
    localparam logic [1:0] INT_ARM       = 2'd0;
    localparam logic [1:0] INT_DRIVER    = 2'd1;
    localparam logic [1:0] INT_PASSENGER = 2'd2;
    localparam logic [1:0] INT_ALARM     = 2'd3;

    // Countdown state machine
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_EXPIRE = 2'd2
    } state_e;

    // Default durations in seconds, also used by the anti-theft FSM
    localparam logic [3:0] DEF_ARM_S       = 4'd6;
    localparam logic [3:0] DEF_DRIVER_S    = 4'd8;
    localparam logic [3:0] DEF_PASSENGER_S = 4'd15;
    localparam logic [3:0] DEF_ALARM_S     = 4'd10;

endpackage
`default_nettype wire

// File: rtl/anti_theft_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : anti_theft_timer_if
// Description : Control/status bundle between the anti-theft FSM (master)
//               and the countdown timer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface anti_theft_timer_if;

    logic       start_timer;
    logic [1:0] interval;
    logic       reprogram;
    logic [1:0] time_param_sel;
    logic [3:0] time_value;
    logic       expired;
    logic       busy;
    logic [3:0] seconds_left;
    logic       one_hz;

    modport master (
        output start_timer, interval, reprogram, time_param_sel, time_value,
        input  expired, busy, seconds_left, one_hz
    );

    modport slave (
        input  start_timer, interval, reprogram, time_param_sel, time_value,
        output expired, busy, seconds_left, one_hz
    );

endinterface
`default_nettype wire

// File: rtl/one_hz_divider.sv
`default_nettype none
// ============================================================================
// Module      : one_hz_divider
// Description : Free-running 0..CLK_HZ-1 counter producing a one-cycle tick
//               per second; restart forces the count back to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module one_hz_divider #(
    parameter int CLK_HZ = 27_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic restart,
    output logic one_hz
);

    // A 1 Hz clock still needs a 1-bit counter to stay legal
    localparam int              CNT_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: restart wins so a new countdown always gets a full first second
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign one_hz = (cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/anti_theft_timer.sv
`default_nettype none
// ============================================================================
// Module      : anti_theft_timer
// Description : Programmable seconds countdown shared by the anti-theft FSM.
//               Loads one of four duration registers on start, counts down
//               on a 1 Hz tick and pulses expired when it reaches zero.
// Revision    : 1.0 - initial release
// ============================================================================
module anti_theft_timer
    import anti_theft_pkg::*;
#(
    parameter int         CLK_HZ          = 27_000_000,
    parameter logic [3:0] T_ARM_DEF       = DEF_ARM_S,
    parameter logic [3:0] T_DRIVER_DEF    = DEF_DRIVER_S,
    parameter logic [3:0] T_PASSENGER_DEF = DEF_PASSENGER_S,
    parameter logic [3:0] T_ALARM_DEF     = DEF_ALARM_S
) (
    input  logic                     clock,
    input  logic                     reset_n,
    anti_theft_timer_if.slave        bus
);

    logic       tick;
    state_e     state_q,   state_d;
    logic [3:0] secs_q,    secs_d;
    logic       busy_q,    busy_d;
    logic       expired_q, expired_d;
    logic [3:0] dur_q [4];
    logic [3:0] dur_d [4];
    logic [3:0] load_val;

    one_hz_divider #(
        .CLK_HZ (CLK_HZ)
    ) u_div (
        .clock   (clock),
        .reset_n (reset_n),
        .restart (bus.start_timer),
        .one_hz  (tick)
    );

    // Start always reads the registered value, so a same-cycle write only
    // affects later starts
    assign load_val = dur_q[bus.interval];

    // Duration register file write port
    always_comb begin
        dur_d = dur_q;
        if (bus.reprogram) begin
            dur_d[bus.time_param_sel] = bus.time_value;
        end
    end

    // Countdown next-state: start has priority over the tick in every state
    always_comb begin
        state_d   = state_q;
        secs_d    = secs_q;
        busy_d    = busy_q;
        expired_d = 1'b0;
        if (bus.start_timer) begin
            secs_d = load_val;
            if (load_val != 4'd0) begin
                state_d = ST_COUNT;
                busy_d  = 1'b1;
            end else begin
                state_d   = ST_EXPIRE;
                busy_d    = 1'b0;
                expired_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_COUNT: begin
                    if (tick) begin
                        if (secs_q == 4'd1) begin
                            state_d   = ST_EXPIRE;
                            secs_d    = 4'd0;
                            busy_d    = 1'b0;
                            expired_d = 1'b1;
                        end else begin
                            secs_d = secs_q - 4'd1;
                        end
                    end
                end
                ST_EXPIRE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State, registered outputs and duration registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q                <= ST_IDLE;
            secs_q                 <= 4'd0;
            busy_q                 <= 1'b0;
            expired_q              <= 1'b0;
            dur_q[INT_ARM]         <= T_ARM_DEF;
            dur_q[INT_DRIVER]      <= T_DRIVER_DEF;
            dur_q[INT_PASSENGER]   <= T_PASSENGER_DEF;
            dur_q[INT_ALARM]       <= T_ALARM_DEF;
        end else begin
            state_q   <= state_d;
            secs_q    <= secs_d;
            busy_q    <= busy_d;
            expired_q <= expired_d;
            dur_q     <= dur_d;
        end
    end

    assign bus.expired      = expired_q;
    assign bus.busy         = busy_q;
    assign bus.seconds_left = secs_q;
    assign bus.one_hz       = tick;

endmodule
`default_nettype wire

// File: doc/anti_theft_timer.md
# anti_theft_timer

Programmable countdown timer shared by the anti-theft FSM for all of its delays: arm delay, driver-door and passenger-door countdowns, and siren-on duration. The FSM pulses `start_timer` with an interval selector. The block loads the selected programmable duration in seconds, counts it down on an internal 1 Hz enable, and pulses `expired`, which drives the FSM's `timer_status` input. A user-side reprogram port rewrites the four duration registers.

## Interface
- `CLK_HZ`, 27_000_000: system clock frequency in Hz; the bench overrides it to 4.
- `T_ARM_DEF`, 6: reset value of the arm delay, in seconds.
- `T_DRIVER_DEF`, 8: reset value of the driver-door delay, in seconds.
- `T_PASSENGER_DEF`, 15: reset value of the passenger-door delay, in seconds.
- `T_ALARM_DEF`, 10: reset value of the siren-on duration, in seconds.

- `clock` in 1: the single clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start_timer` in 1: one-cycle start/restart request from the FSM.
- `interval` in 2: selects which duration `start_timer` loads.
- `reprogram` in 1: one-cycle write strobe for a duration register.
- `time_param_sel` in 2: selects the duration register to write.
- `time_value` in 4: new duration value, 0–15 s.
- `expired` out 1: one-cycle pulse when the countdown completes.
- `busy` out 1: high while counting.
- `seconds_left` out 4: remaining whole seconds, for the display.
- `one_hz` out 1: one-cycle tick, once per `CLK_HZ` cycles; also used for status-LED blink.

## Operation
- Reset values: `expired`=0, `busy`=0, `seconds_left`=0. The four duration registers reset to their `*_DEF` values, the divider count to 0, and the state to IDLE.
- Interval encoding: 0 = ARM, 1 = DRIVER, 2 = PASSENGER, 3 = ALARM. The same encoding applies to `interval` and `time_param_sel`.
- Divider: a counter runs 0..`CLK_HZ`-1 and `one_hz` = (count == `CLK_HZ`-1).
  - It free-runs in every state.
  - `start_timer` forces it to 0, so the first second is always a full second.
- States: IDLE, COUNT, EXPIRE.
  - **IDLE:** on `start_timer`, load `seconds_left` from the selected register. If the value is ≥1, go to COUNT; if it is 0, go to EXPIRE.
  - **COUNT** (`busy`=1):
    - On `one_hz` with `seconds_left`==1, go to EXPIRE and set `seconds_left` to 0.
    - On `one_hz` otherwise, decrement `seconds_left`.
    - `start_timer` takes priority over `one_hz`: reload, reset the divider and stay in COUNT (or go to EXPIRE if the new value is 0). No `expired` pulse is produced for the abandoned count.
  - **EXPIRE:** `expired`=1 for exactly one cycle, then return to IDLE.
    - `start_timer` in this cycle is honoured: the pulse still completes and the block goes directly to COUNT (or EXPIRE) with the new value.
- Reprogram:
  - On `reprogram`, the register selected by `time_param_sel` takes `time_value`.
  - A write never alters a countdown already in progress.
  - If `reprogram` and `start_timer` arrive in the same cycle for the same register, the start loads the pre-write value; the new value applies from the next start.
- Arithmetic: `seconds_left` is 4-bit unsigned. It never wraps, because COUNT exits at 1.

## Timing
- The start is sampled at edge E.
- `busy` and `seconds_left`=N are visible after E.
- `seconds_left` decrements after edges E+k·`CLK_HZ`, for k = 1..N-1.
- `expired` is high for the single cycle following edge E+N·`CLK_HZ`.
- N=0: `expired` is high in the cycle immediately following E, and `busy` stays 0.
- `reset_n` low mid-operation clears all outputs, state and divider immediately (asynchronously) and restores the default durations. No `expired` pulse is generated.

## Structure
- Shared package `anti_theft_pkg` holds:
  - the interval encodings (`INT_ARM`, `INT_DRIVER`, `INT_PASSENGER`, `INT_ALARM`);
  - the state enum;
  - the default durations, shared with the FSM.
- Sub-module `one_hz_divider` contains the divider. Its ports are `clock`, `reset_n`, `restart` and `one_hz`, and its counter width is $clog2(`CLK_HZ`).
- The parameter register file, state machine and countdown live in the top module.

## Test plan
All scenarios use `CLK_HZ`=4.
- **Defaults:** release reset, then start ARM → `busy` high for 24 cycles, `seconds_left` goes 6→1, and `expired` pulses once, exactly 24 cycles after the start edge.
- **Reprogram:** write PASSENGER=3, then start PASSENGER → `seconds_left` goes 3,2,1 and `expired` pulses at cycle 12.
- **Restart:** start DRIVER, and 10 cycles later start ALARM → no pulse at cycle 32; `expired` pulses 40 cycles after the second start.
- **Zero value:** write ALARM=0, then start ALARM → `expired` is high the next cycle and `busy` never rises.
- **Reset mid-count:** start DRIVER, then drive `reset_n` low at cycle 10 → `busy`, `seconds_left` and `expired` go to 0 immediately. After release, start DRIVER expires at cycle 32 (default restored).
- **Write/start collision:** in the same cycle write ARM=2 and start ARM → expiry at cycle 24 (old value). A second start ARM → expiry at cycle 8.
